// File: rtl/pwd_verify_seq.sv
// rtl/pwd_verify_seq.sv - constant-time serial code compare with failure counting and timed lockout
// Optional master-code path (accepted during lockout, clears it on match) enabled by MASTER_CODE_EN.
module pwd_verify_seq #(
  parameter int NUM_DIGITS     = 6,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       code_in,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       code_ref,
`ifdef MASTER_CODE_EN
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       master_code,
`endif
  output logic                                busy,
  output logic                                done,
  output logic                                match,
  output logic                                reject,
  output logic                                alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0]      fail_cnt
);

  localparam int CW = NUM_DIGITS * DIGIT_W;
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
`ifdef MASTER_CODE_EN
  localparam bit MASTER_EN = 1'b1;
`else
  localparam bit MASTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMP, RESULT, LOCK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   in_q, in_d, ref_q, ref_d;
  logic            mis_q, mis_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            match_q, match_d;
  logic            done_q, done_d;
  logic            reject_q, reject_d;
  logic            alarm_q, alarm_d;
  logic            relock_q, relock_d;
`ifdef MASTER_CODE_EN
  logic [CW-1:0]   mst_q, mst_d;
  logic            mmis_q, mmis_d;
`endif

  logic take;
  logic code_ok;
  logic master_ok;

  always_comb begin
    state_d  = state_q;
    in_d     = in_q;
    ref_d    = ref_q;
    mis_d    = mis_q;
    idx_d    = idx_q;
    lock_d   = lock_q;
    fail_d   = fail_q;
    match_d  = match_q;
    done_d   = 1'b0;
    alarm_d  = alarm_q;
    relock_d = relock_q;
`ifdef MASTER_CODE_EN
    mst_d     = mst_q;
    mmis_d    = mmis_q;
    code_ok   = ~mis_q | ~mmis_q;
    master_ok = ~mmis_q;
`else
    code_ok   = ~mis_q;
    master_ok = 1'b0;
`endif

    take     = start && (state_q == IDLE || (MASTER_EN && state_q == LOCK));
    reject_d = start && !take;

    case (state_q)
      IDLE: ;
      CMP: begin
        // Low digit is always the current one; snapshots shift down each cycle.
        mis_d = mis_q | (in_q[DIGIT_W-1:0] != ref_q[DIGIT_W-1:0]);
        in_d  = in_q >> DIGIT_W;
        ref_d = ref_q >> DIGIT_W;
`ifdef MASTER_CODE_EN
        mmis_d = mmis_q | (in_q[DIGIT_W-1:0] != mst_q[DIGIT_W-1:0]);
        mst_d  = mst_q >> DIGIT_W;
`endif
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_DIGITS - 1)) state_d = RESULT;
      end
      RESULT: begin
        done_d  = 1'b1;
        match_d = code_ok;
        state_d = IDLE;
        if (relock_q && master_ok) begin
          fail_d  = '0;
          alarm_d = 1'b0;
        end else if (relock_q) begin
          lock_d  = LW'(LOCKOUT_CYCLES);
          state_d = LOCK;
        end else if (code_ok) begin
          fail_d = '0;
        end else if (int'(fail_q) + 1 < MAX_TRIES) begin
          fail_d = fail_q + 1'b1;
        end else begin
          fail_d  = FW'(MAX_TRIES);
          lock_d  = LW'(LOCKOUT_CYCLES);
          alarm_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (lock_q <= LW'(1)) begin
          lock_d  = '0;
          fail_d  = '0;
          alarm_d = 1'b0;
          state_d = IDLE;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start on the final lockout cycle is treated as an ordinary attempt.
    if (take) begin
      in_d     = code_in;
      ref_d    = code_ref;
      mis_d    = 1'b0;
      idx_d    = '0;
      relock_d = (state_q == LOCK) && (lock_q > LW'(1));
      state_d  = CMP;
`ifdef MASTER_CODE_EN
      mst_d  = master_code;
      mmis_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      in_q     <= '0;
      ref_q    <= '0;
      mis_q    <= 1'b0;
      idx_q    <= '0;
      lock_q   <= '0;
      fail_q   <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      alarm_q  <= 1'b0;
      relock_q <= 1'b0;
`ifdef MASTER_CODE_EN
      mst_q    <= '0;
      mmis_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      ref_q    <= ref_d;
      mis_q    <= mis_d;
      idx_q    <= idx_d;
      lock_q   <= lock_d;
      fail_q   <= fail_d;
      match_q  <= match_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      alarm_q  <= alarm_d;
      relock_q <= relock_d;
`ifdef MASTER_CODE_EN
      mst_q    <= mst_d;
      mmis_q   <= mmis_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign match    = match_q;
  assign reject   = reject_q;
  assign alarm    = alarm_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_pwd_verify_seq.sv
// tb/tb_pwd_verify_seq.sv - scoreboard bench for pwd_verify_seq
module tb_pwd_verify_seq;
  localparam int N  = 6;
  localparam int W  = 4;
  localparam int MT = 3;
  localparam int LC = 20;
  localparam int CW = N * W;
  localparam int FW = $clog2(MT + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] code_in = '0;
  logic [CW-1:0] code_ref = 24'h123456;
`ifdef MASTER_CODE_EN
  logic [CW-1:0] master_code = 24'h999999;
`endif
  logic          busy, done, match, reject, alarm;
  logic [FW-1:0] fail_cnt;

  typedef struct {
    int cyc;
    bit m;
    int f;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_fail = 0;
  int   alarm_rise = -1;
  int   alarm_fall = -1;
  int   last_done = -1;
  logic alarm_prev = 1'b0;

  pwd_verify_seq #(
    .NUM_DIGITS(N), .DIGIT_W(W), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .code_in(code_in), .code_ref(code_ref),
`ifdef MASTER_CODE_EN
    .master_code(master_code),
`endif
    .busy(busy), .done(done), .match(match), .reject(reject),
    .alarm(alarm), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        last_done = cyc;
        if (sbq.size() == 0) check_eq("done_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          check_eq("done_latency", cyc, e.cyc);
          check_eq("match", match, int'(e.m));
          check_eq("fail_cnt", fail_cnt, e.f);
        end
      end
      if (alarm && !alarm_prev) alarm_rise = cyc;
      if (!alarm && alarm_prev) alarm_fall = cyc;
    end
    alarm_prev = alarm;
  end

  function automatic void predict(input logic [CW-1:0] c, output bit m, output int f);
    m = (c == code_ref);
`ifdef MASTER_CODE_EN
    m = m || (c == master_code);
`endif
    if (m) model_fail = 0;
    else if (model_fail + 1 < MT) model_fail++;
    else model_fail = MT;
    f = model_fail;
  endfunction

  task automatic launch(input logic [CW-1:0] c);
    exp_t e;
    bit   m;
    int   f;
    @(negedge clk);
    code_in = c;
    start   = 1'b1;
    @(posedge clk);
    #1;
    predict(c, m, f);
    e.cyc = cyc + N + 1;
    e.m   = m;
    e.f   = f;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("no_reject_on_accept", reject, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
    check_eq("done_timeout_pending", sbq.size(), 0);
  endtask

  task automatic attempt(input logic [CW-1:0] c);
    launch(c);
    wait_done();
  endtask

  task automatic pulse_reject(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq(tag, reject, 1);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_alarm"}, alarm, 0);
    check_eq({tag, "_fail_cnt"}, fail_cnt, 0);
    sbq.delete();
    model_fail = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_match", match, 0);
    check_eq("rst_reject", reject, 0);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0;

    attempt(24'h123456);
    attempt(24'h123457);
    attempt(24'h023456);
    attempt(24'h123456);
    attempt(24'h123457);
    check_eq("no_alarm_after_one_fail", alarm, 0);

    attempt(24'h123456);
    attempt(24'h000000);
    attempt(24'h654321);
    attempt(24'h123450);
    check_eq("alarm_rise_at_done", alarm_rise, last_done);
`ifndef MASTER_CODE_EN
    pulse_reject("reject_in_lock");
`endif
    for (int i = 0; i < 100 && alarm; i++) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("lockout_length", alarm_fall - alarm_rise, LC);
    check_eq("fail_cnt_after_lock", fail_cnt, 0);
    model_fail = 0;
    attempt(24'h123456);

    launch(24'h123456);
    code_in = 24'hFFFFFF;
    pulse_reject("reject_mid_cmp");
    wait_done();

    attempt(24'h111111);
    launch(24'h123456);
    repeat (2) @(posedge clk);
    async_reset_check("rst_cmp");
    attempt(24'h123456);

    attempt(24'h111111);
    attempt(24'h222222);
    attempt(24'h333333);
    repeat (5) @(posedge clk);
    async_reset_check("rst_lock");
    attempt(24'h123456);

`ifdef MASTER_CODE_EN
    attempt(24'h111111);
    attempt(24'h222222);
    attempt(24'h333333);
    repeat (3) @(posedge clk);
    attempt(24'h999999);
    check_eq("master_clears_alarm", alarm, 0);
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
